// File: rtl/ow_slave_phy.sv
// rtl/ow_slave_phy.sv - 1-Wire slave bit-level front end: reset/presence handling, slot decode, read-0 drive
module ow_slave_phy #(
    parameter int CNT_W     = 10,
    parameter int RST_MIN   = 480,
    parameter int PD_WAIT   = 30,
    parameter int PD_LEN    = 120,
    parameter int SAMPLE_PT = 30,
    parameter int RD_HOLD   = 30,
    parameter int SLOT_MIN  = 60
) (
    input  logic CLK,
    input  logic RST,
    input  logic OW_IN,
    output logic OW_OE,
    output logic IOX_RSTZ,
    output logic CLK_MEM,
    output logic IOX_WRDATA,
    input  logic IOX_RDDATA,
    input  logic IOX_READZ,
    input  logic END_1WIRE
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_MIN - 1);
    localparam logic [CNT_W-1:0] PD_DLY_LAST = CNT_W'(PD_WAIT - 1);
    localparam logic [CNT_W-1:0] PD_DRV_LAST = CNT_W'(PD_LEN - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT   = CNT_W'(SAMPLE_PT);
    localparam logic [CNT_W-1:0] RISE_AT     = CNT_W'(SAMPLE_PT + 1);
    localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(RD_HOLD);
    localparam logic [CNT_W-1:0] SLOT_END    =
        CNT_W'((SLOT_MIN > SAMPLE_PT + 2) ? SLOT_MIN : SAMPLE_PT + 2);

    typedef enum logic [2:0] {
        IDLE, RST_DET, PD_DLY, PD_DRV, PD_REC, SLOT_WAIT, SLOT_ACT
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       sync_q;
    logic             line, line_d;
    logic [CNT_W-1:0] low_cnt, low_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             oe_nxt, rstz_nxt, clk_nxt, wr_nxt;
    logic             rst_hit, fall;

    assign line    = sync_q[1];
    assign fall    = line_d & ~line & ~OW_OE;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    // Our own pulls hold the low counter so presence/read-0 never look like a master reset
    assign rst_hit = ~line & ~OW_OE & (low_cnt == RST_LAST);

    always_comb begin
        low_nxt = low_cnt;
        if (line)
            low_nxt = '0;
        else if (!OW_OE && low_cnt != CNT_MAX)
            low_nxt = low_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= 2'b11;
            line_d  <= 1'b1;
            low_cnt <= '0;
        end else begin
            sync_q  <= {sync_q[0], OW_IN};
            line_d  <= line;
            low_cnt <= low_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            OW_OE      <= 1'b0;
            IOX_RSTZ   <= 1'b0;
            CLK_MEM    <= 1'b0;
            IOX_WRDATA <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            OW_OE      <= oe_nxt;
            IOX_RSTZ   <= rstz_nxt;
            CLK_MEM    <= clk_nxt;
            IOX_WRDATA <= wr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        oe_nxt    = OW_OE;
        rstz_nxt  = IOX_RSTZ;
        clk_nxt   = CLK_MEM;
        wr_nxt    = IOX_WRDATA;
        if (rst_hit) begin
            state_nxt = RST_DET;
            cnt_nxt   = '0;
            oe_nxt    = 1'b0;
            rstz_nxt  = 1'b0;
            clk_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                RST_DET: begin
                    cnt_nxt = '0;
                    if (line)
                        state_nxt = PD_DLY;
                end
                PD_DLY: begin
                    if (cnt == PD_DLY_LAST) begin
                        state_nxt = PD_DRV;
                        cnt_nxt   = '0;
                        oe_nxt    = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                PD_DRV: begin
                    if (cnt == PD_DRV_LAST) begin
                        state_nxt = PD_REC;
                        cnt_nxt   = '0;
                        oe_nxt    = 1'b0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                PD_REC: begin
                    if (line) begin
                        rstz_nxt  = 1'b1;
                        state_nxt = SLOT_WAIT;
                    end
                end
                SLOT_WAIT: begin
                    if (fall && !END_1WIRE) begin
                        state_nxt = SLOT_ACT;
                        cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                        oe_nxt    = ~IOX_READZ & ~IOX_RDDATA;
                    end
                end
                SLOT_ACT: begin
                    cnt_nxt = cnt_inc;
                    if (OW_OE && cnt == HOLD_END)
                        oe_nxt = 1'b0;
                    if (cnt == SAMPLE_AT)
                        wr_nxt = line;
                    if (cnt == RISE_AT)
                        clk_nxt = 1'b1;
                    // A line still held low keeps CLK_MEM high until it rises or becomes a reset
                    if (line && cnt >= SLOT_END) begin
                        clk_nxt   = 1'b0;
                        state_nxt = SLOT_WAIT;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ow_slave_phy.sv
// tb/tb_ow_slave_phy.sv - randomized self-checking bench for ow_slave_phy with a timestamp-based bus model
module tb_ow_slave_phy;

    localparam int CNT_W     = 10;
    localparam int RST_MIN   = 480;
    localparam int PD_WAIT   = 30;
    localparam int PD_LEN    = 120;
    localparam int SAMPLE_PT = 30;
    localparam int RD_HOLD   = 30;
    localparam int SLOT_MIN  = 60;
    localparam int SLOT_END  = (SLOT_MIN > SAMPLE_PT + 2) ? SLOT_MIN : SAMPLE_PT + 2;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic master = 1'b1;
    logic IOX_RDDATA = 1'b1;
    logic IOX_READZ = 1'b1;
    logic END_1WIRE = 1'b0;
    logic OW_IN, OW_OE, IOX_RSTZ, CLK_MEM, IOX_WRDATA;

    // Open-drain bus: master and slave both pull low
    assign OW_IN = master & ~OW_OE;

    always #5 CLK = ~CLK;

    ow_slave_phy #(
        .CNT_W(CNT_W), .RST_MIN(RST_MIN), .PD_WAIT(PD_WAIT), .PD_LEN(PD_LEN),
        .SAMPLE_PT(SAMPLE_PT), .RD_HOLD(RD_HOLD), .SLOT_MIN(SLOT_MIN)
    ) dut (
        .CLK(CLK), .RST(RST), .OW_IN(OW_IN), .OW_OE(OW_OE), .IOX_RSTZ(IOX_RSTZ),
        .CLK_MEM(CLK_MEM), .IOX_WRDATA(IOX_WRDATA), .IOX_RDDATA(IOX_RDDATA),
        .IOX_READZ(IOX_READZ), .END_1WIRE(END_1WIRE)
    );

    // Reference model: phases plus entry timestamps, ages derived from the cycle number
    typedef enum {PH_OFF, PH_RESET_SEEN, PH_PRESENCE, PH_RECOVER, PH_SLOTS, PH_IN_SLOT} phase_t;
    phase_t ph = PH_OFF;
    logic m_oe = 1'b0, m_rstz = 1'b0, m_clk = 1'b0, m_wr = 1'b1;
    logic ms1 = 1'b1, msl = 1'b1, msld = 1'b1;
    int   mk = 0, t0 = 0, lowc = 0;

    initial begin : model
        logic bus, lp, ldp, oe_old;
        int   age, lowc_old;
        forever begin
            @(posedge CLK);
            mk++;
            bus    = master & ~m_oe;
            lp     = msl;
            ldp    = msld;
            oe_old = m_oe;
            if (RST) begin
                ph = PH_OFF; m_oe = 1'b0; m_rstz = 1'b0; m_clk = 1'b0; m_wr = 1'b1;
                ms1 = 1'b1; msl = 1'b1; msld = 1'b1; lowc = 0;
            end else begin
                lowc_old = lowc;
                if (lp) lowc = 0;
                else if (!oe_old && lowc < CNT_SAT) lowc = lowc + 1;
                if (!lp && !oe_old && lowc_old == RST_MIN - 1) begin
                    m_rstz = 1'b0; m_clk = 1'b0; m_oe = 1'b0; ph = PH_RESET_SEEN;
                end else begin
                    case (ph)
                        PH_RESET_SEEN: if (lp) begin ph = PH_PRESENCE; t0 = mk; end
                        PH_PRESENCE: begin
                            if (mk - t0 == PD_WAIT) m_oe = 1'b1;
                            if (mk - t0 == PD_WAIT + PD_LEN) begin m_oe = 1'b0; ph = PH_RECOVER; end
                        end
                        PH_RECOVER: if (lp) begin m_rstz = 1'b1; ph = PH_SLOTS; end
                        PH_SLOTS: begin
                            if (ldp && !lp && !oe_old && !END_1WIRE) begin
                                ph = PH_IN_SLOT; t0 = mk; m_oe = !IOX_READZ && !IOX_RDDATA;
                            end
                        end
                        PH_IN_SLOT: begin
                            age = mk - t0;
                            if (age > CNT_SAT) age = CNT_SAT;
                            if (oe_old && age == RD_HOLD) m_oe = 1'b0;
                            if (age == SAMPLE_PT) m_wr = lp;
                            if (age == SAMPLE_PT + 1) m_clk = 1'b1;
                            if (lp && age >= SLOT_END) begin m_clk = 1'b0; ph = PH_SLOTS; end
                        end
                        default: ;
                    endcase
                end
                msld = msl; msl = ms1; ms1 = bus;
            end
        end
    end

    int   n_cmp = 0, n_fail = 0;
    int   rises, oe_cycles, t_oe_rise, t_rstz_fall, t_rstz_rise, t_clk_fall;
    logic bits[$];
    logic p_clk = 1'b0, p_rstz = 1'b0, p_oe = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic clr_mon();
        rises = 0; oe_cycles = 0; bits.delete();
        t_oe_rise = -1; t_rstz_fall = -1; t_rstz_rise = -1; t_clk_fall = -1;
    endtask

    // One bus cycle: compare against the model, update monitors, then drive the master level
    task automatic tick(input logic m);
        @(negedge CLK);
        n_cmp++;
        if ({OW_OE, IOX_RSTZ, CLK_MEM, IOX_WRDATA} !== {m_oe, m_rstz, m_clk, m_wr}) begin
            n_fail++;
            $display("FAIL model_cmp cyc=%0d oe,rstz,clk,wr got %b%b%b%b want %b%b%b%b",
                     mk, OW_OE, IOX_RSTZ, CLK_MEM, IOX_WRDATA, m_oe, m_rstz, m_clk, m_wr);
        end
        if (CLK_MEM && !p_clk) begin rises++; bits.push_back(IOX_WRDATA); end
        if (!CLK_MEM && p_clk) t_clk_fall = mk;
        if (!IOX_RSTZ && p_rstz) t_rstz_fall = mk;
        if (IOX_RSTZ && !p_rstz) t_rstz_rise = mk;
        if (OW_OE && !p_oe && t_oe_rise < 0) t_oe_rise = mk;
        if (OW_OE) oe_cycles++;
        p_clk = CLK_MEM; p_rstz = IOX_RSTZ; p_oe = OW_OE;
        master = m;
    endtask

    task automatic hold(input logic m, input int n);
        repeat (n) tick(m);
    endtask

    task automatic slot(input int lo, input int total);
        hold(1'b0, lo);
        hold(1'b1, total - lo);
    endtask

    task automatic bus_reset(input int lo, output int k_lo, output int k_hi);
        tick(1'b0);
        k_lo = mk;
        hold(1'b0, lo - 1);
        tick(1'b1);
        k_hi = mk;
        hold(1'b1, 300);
    endtask

    function automatic int bit_at(input int i);
        return (i < bits.size()) ? int'(bits[i]) : -1;
    endfunction

    initial begin : stim
        int klo, khi, k0, n, lo, total;
        logic [7:0] wbyte;
        clr_mon();
        hold(1'b1, 3);
        chk("rst_oe", int'(OW_OE), 0);
        chk("rst_rstz", int'(IOX_RSTZ), 0);
        chk("rst_clk", int'(CLK_MEM), 0);
        chk("rst_wr", int'(IOX_WRDATA), 1);
        RST = 1'b0;
        hold(1'b1, 20);

        // Reset pulse and presence: 1 drive + 2 sync + 30 wait; release then 2+1 to see line high
        clr_mon();
        bus_reset(500, klo, khi);
        chk("t1_oe_start", t_oe_rise - khi, 33);
        chk("t1_oe_len", oe_cycles, 120);
        chk("t1_rstz_rise", t_rstz_rise - khi, 156);

        clr_mon();
        wbyte = 8'h0F;
        for (int i = 0; i < 8; i++) slot(wbyte[i] ? 6 : 60, 70);
        hold(1'b1, 10);
        chk("t2_pulses", rises, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_bit%0d", i), bit_at(i), (i < 4) ? 1 : 0);

        IOX_READZ = 1'b0; IOX_RDDATA = 1'b0;
        clr_mon();
        tick(1'b0); k0 = mk; hold(1'b0, 5); hold(1'b1, 64);
        chk("t3_oe_start", t_oe_rise - k0, 3);
        chk("t3_oe_len", oe_cycles, 30);
        chk("t3_bit", bit_at(0), 0);
        IOX_RDDATA = 1'b1;
        clr_mon();
        slot(6, 70);
        chk("t3_oe_len_rd1", oe_cycles, 0);
        chk("t3_bit_rd1", bit_at(0), 1);

        clr_mon();
        for (int i = 0; i < 40; i++) begin
            IOX_READZ  = 1'($urandom_range(0, 1));
            IOX_RDDATA = 1'($urandom_range(0, 1));
            lo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : int'($urandom_range(35, 110));
            total = lo + int'($urandom_range(8, 40));
            if (total < 70) total = 70;
            slot(lo, total);
        end
        hold(1'b1, 20);
        chk("rand_pulses", rises, 40);

        IOX_READZ = 1'b0; IOX_RDDATA = 1'b0; END_1WIRE = 1'b1;
        clr_mon();
        repeat (5) slot(6, 70);
        chk("t4_pulses", rises, 0);
        chk("t4_oe", oe_cycles, 0);
        clr_mon();
        bus_reset(500, klo, khi);
        chk("t4_rstz_fall", t_rstz_fall - klo, 482);
        chk("t4_oe_len", oe_cycles, 120);
        chk("t4_rstz_rise", t_rstz_rise - khi, 156);
        END_1WIRE = 1'b0; IOX_READZ = 1'b1; IOX_RDDATA = 1'b1;

        clr_mon();
        tick(1'b0); k0 = mk; hold(1'b0, 5); hold(1'b1, 4);
        tick(1'b0); klo = mk; hold(1'b0, 499);
        tick(1'b1); khi = mk; hold(1'b1, 300);
        chk("t5_pulses", rises, 1);
        chk("t5_clk_fall", t_clk_fall - klo, 482);
        chk("t5_rstz_fall", t_rstz_fall - klo, 482);
        chk("t5_oe_len", oe_cycles, 120);
        chk("t5_rstz_rise", t_rstz_rise - khi, 156);

        clr_mon();
        tick(1'b0); hold(1'b0, 499); tick(1'b1);
        n = 0;
        while (OW_OE !== 1'b1 && n < 200) begin tick(1'b1); n++; end
        chk("t6_oe_seen", int'(OW_OE), 1);
        hold(1'b1, 10);
        RST = 1'b1;
        tick(1'b1);
        chk("t6_oe", int'(OW_OE), 0);
        chk("t6_rstz", int'(IOX_RSTZ), 0);
        RST = 1'b0;
        clr_mon();
        repeat (3) slot(6, 70);
        chk("t6_idle_pulses", rises, 0);
        chk("t6_idle_oe", oe_cycles, 0);
        clr_mon();
        bus_reset(500, klo, khi);
        chk("t6_oe_len", oe_cycles, 120);
        chk("t6_rstz_rise", t_rstz_rise - khi, 156);
        hold(1'b1, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
